// File: rtl/note_arbiter.sv
// note_arbiter: fixed-priority owner of the single tone generator, enforcing a minimum note hold.
// Define NOTE_GAP_EN to insert GAP_CYCLES silent cycles before every new tone.
module note_arbiter #(
  parameter int MIN_HOLD_CYCLES = 5_000_000,
  parameter int GAP_CYCLES      = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [11:0] note_req,
  input  logic [5:0]  octave_req,
  output logic [2:0]  grant,
  output logic [3:0]  note_out,
  output logic [1:0]  octave_out,
  output logic        busy
);
  localparam int HW = $clog2(MIN_HOLD_CYCLES + 1);

  if (MIN_HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
    $error("note_arbiter: MIN_HOLD_CYCLES and GAP_CYCLES must be >= 1");
  end

`ifdef NOTE_GAP_EN
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  logic [GW-1:0] gap_cnt_q;
`else
  typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

  state_t        state_q;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]    act, win_oh;
  logic [3:0]    win_note;
  logic [1:0]    win_oct;
  logic          any_act, hold_met, tone_change;

  for (genvar gi = 0; gi < 3; gi++) begin : g_act
    assign act[gi] = req[gi] && (note_req[4*gi +: 4] != 4'd0);
  end

  // Lowest set bit of act is the highest-priority active source.
  assign win_oh  = act & (~act + 3'd1);
  assign any_act = |act;

  always_comb begin
    win_note = 4'd0;
    win_oct  = 2'd0;
    if (act[0]) begin
      win_note = note_req[3:0];
      win_oct  = octave_req[1:0];
    end else if (act[1]) begin
      win_note = note_req[7:4];
      win_oct  = octave_req[3:2];
    end else if (act[2]) begin
      win_note = note_req[11:8];
      win_oct  = octave_req[5:4];
    end
  end

  assign hold_met    = hold_cnt_q >= HW'(MIN_HOLD_CYCLES);
  assign hold_cnt_d  = hold_met ? hold_cnt_q : hold_cnt_q + HW'(1);
  // Covers preemption, hand-over to a lower source and re-tone by the owner.
  assign tone_change = (win_oh != grant) || (win_note != note_out) || (win_oct != octave_out);
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant      <= 3'd0;
      note_out   <= 4'd0;
      octave_out <= 2'd0;
      hold_cnt_q <= '0;
`ifdef NOTE_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_act) begin
            state_q    <= PLAY;
            grant      <= win_oh;
            note_out   <= win_note;
            octave_out <= win_oct;
            hold_cnt_q <= HW'(1);
          end
        end
        PLAY: begin
          hold_cnt_q <= hold_cnt_d;
          if (hold_met && (!any_act || tone_change)) begin
`ifdef NOTE_GAP_EN
            state_q    <= GAP;
            gap_cnt_q  <= GW'(1);
            grant      <= 3'd0;
            note_out   <= 4'd0;
            octave_out <= 2'd0;
`else
            if (any_act) begin
              grant      <= win_oh;
              note_out   <= win_note;
              octave_out <= win_oct;
              hold_cnt_q <= HW'(1);
            end else begin
              state_q    <= IDLE;
              grant      <= 3'd0;
              note_out   <= 4'd0;
              octave_out <= 2'd0;
            end
`endif
          end
        end
`ifdef NOTE_GAP_EN
        GAP: begin
          if (gap_cnt_q < GW'(GAP_CYCLES)) begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end else begin
            gap_cnt_q <= '0;
            if (any_act) begin
              state_q    <= PLAY;
              grant      <= win_oh;
              note_out   <= win_note;
              octave_out <= win_oct;
              hold_cnt_q <= HW'(1);
            end else begin
              state_q <= IDLE;
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
